// File: rtl/pe_pkg.sv
// Shared PE datapath types: coefficient word, modulus constants, algorithm select.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package pe_pkg;

  localparam int W      = 23;
  localparam int STAGES = 3;

  typedef logic [W-1:0] coeff_t;

  localparam coeff_t Q_KYBER     = 23'd3329;
  localparam coeff_t Q_DILITHIUM = 23'd8380417;

  typedef enum logic {SEL_KYBER, SEL_DILITHIUM} alg_sel_e;

  function automatic coeff_t q_of(alg_sel_e sel);
    return (sel == SEL_DILITHIUM) ? Q_DILITHIUM : Q_KYBER;
  endfunction

endpackage

// File: rtl/ntt_butterfly_if.sv
// Operand/result bundle between fetch unit, butterfly and writeback buffer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and result sides.
//  Input side : in_valid_i, in_ready_o, sel_i, a_i, b_i, w_i
//  Output side: out_valid_o, out_ready_i, sel_o, hi_o, lo_o, busy_o
interface ntt_butterfly_if;
  import pe_pkg::*;

  logic   in_valid_i;
  logic   in_ready_o;
  logic   sel_i;
  coeff_t a_i;
  coeff_t b_i;
  coeff_t w_i;
  logic   out_valid_o;
  logic   out_ready_i;
  logic   sel_o;
  coeff_t hi_o;
  coeff_t lo_o;
  logic   busy_o;

  // master = upstream producer plus downstream consumer (the environment)
  modport master (
    output in_valid_i, sel_i, a_i, b_i, w_i, out_ready_i,
    input  in_ready_o, out_valid_o, sel_o, hi_o, lo_o, busy_o
  );

  // slave = the butterfly itself
  modport slave (
    input  in_valid_i, sel_i, a_i, b_i, w_i, out_ready_i,
    output in_ready_o, out_valid_o, sel_o, hi_o, lo_o, busy_o
  );
endinterface

// File: rtl/mod_addsub.sv
// Butterfly add/sub: hi = (a+t) mod q, lo = (a-t) mod q with a, t < q.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
//  a_i, t_i : operands < q ; sel_i : modulus select ; hi_o, lo_o : results
module mod_addsub
  import pe_pkg::*;
(
  input  coeff_t   a_i,
  input  coeff_t   t_i,
  input  alg_sel_e sel_i,
  output coeff_t   hi_o,
  output coeff_t   lo_o
);

  logic [W:0] q;
  logic [W:0] sum;
  logic [W:0] dif;
  logic [W:0] hi_w;
  logic [W:0] lo_w;

  assign q   = {1'b0, q_of(sel_i)};
  assign sum = {1'b0, a_i} + {1'b0, t_i};
  assign dif = {1'b0, a_i} - {1'b0, t_i};

  // One conditional correction suffices since both operands are below q.
  assign hi_w = (sum >= q) ? (sum - q) : sum;
  assign lo_w = (a_i < t_i) ? (dif + q) : dif;

  assign hi_o = coeff_t'(hi_w);
  assign lo_o = coeff_t'(lo_w);

endmodule

// File: rtl/mod_mul.sv
// Modular multiply t = x*y mod q, q chosen by select_i.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
//  x_i, y_i : operands < q ; select_i : 0 Kyber, 1 Dilithium ; t_o : product mod q
module mod_mul
  import pe_pkg::*;
(
  input  coeff_t   x_i,
  input  coeff_t   y_i,
  input  alg_sel_e select_i,
  output coeff_t   t_o
);

  logic [2*W-1:0] product;
  logic [23:0]    red_k;
  logic [2*W-1:0] red_d;

  assign product = {{W{1'b0}}, x_i} * {{W{1'b0}}, y_i};

  // Kyber reduction only looks at the low 24 product bits; operands < 2^12
  // keep the full product inside that window.
  assign red_k = product[23:0] % 24'(Q_KYBER);
  assign red_d = product % (2*W)'(Q_DILITHIUM);

  assign t_o = (select_i == SEL_DILITHIUM) ? coeff_t'(red_d) : coeff_t'(red_k);

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined Cooley-Tukey butterfly: hi = a + b*w, lo = a - b*w (mod q per op).
// Latency: 3 cycles from input transfer to out_valid_o, 1 op/cycle.
// Backpressure: global stall when S3 is full and out_ready_i=0; in_ready_o follows it combinationally.
//  clk_i, rst_ni : clock and async active-low reset
//  bus           : operand/result handshake bundle (slave side)
module ntt_butterfly
  import pe_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  ntt_butterfly_if.slave  bus
);

  logic     adv;
  logic     v1, v2, v3;
  coeff_t   a1, b1, w1;
  alg_sel_e s1;
  coeff_t   a2, t2;
  alg_sel_e s2;
  coeff_t   hi3, lo3;
  alg_sel_e s3;
  coeff_t   t_mul;
  coeff_t   hi_c, lo_c;

  // The only holding point is S3; everything upstream shifts with it,
  // bubbles included, so a free S3 or a consuming sink lets all stages move.
  assign adv = ~v3 | bus.out_ready_i;

  mod_mul u_mul (
    .x_i      (b1),
    .y_i      (w1),
    .select_i (s1),
    .t_o      (t_mul)
  );

  mod_addsub u_addsub (
    .a_i   (a2),
    .t_i   (t2),
    .sel_i (s2),
    .hi_o  (hi_c),
    .lo_o  (lo_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      w1  <= '0;
      s1  <= SEL_KYBER;
      a2  <= '0;
      t2  <= '0;
      s2  <= SEL_KYBER;
      hi3 <= '0;
      lo3 <= '0;
      s3  <= SEL_KYBER;
    end else if (adv) begin
      v1  <= bus.in_valid_i;
      a1  <= bus.a_i;
      b1  <= bus.b_i;
      w1  <= bus.w_i;
      s1  <= alg_sel_e'(bus.sel_i);
      v2  <= v1;
      a2  <= a1;
      t2  <= t_mul;
      s2  <= s1;
      v3  <= v2;
      hi3 <= hi_c;
      lo3 <= lo_c;
      s3  <= s2;
    end
  end

  assign bus.in_ready_o  = adv;
  assign bus.out_valid_o = v3;
  assign bus.sel_o       = s3;
  assign bus.hi_o        = hi3;
  assign bus.lo_o        = lo3;
  assign bus.busy_o      = v1 | v2 | v3;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed cases plus randomized traffic
// against an arithmetic reference model. Inputs change and outputs are sampled
// on the falling edge.
module tb_ntt_butterfly;

  typedef struct {
    logic    sel;
    longint  hi;
    longint  lo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   failed;
  int   total;

  ntt_butterfly_if bus ();

  ntt_butterfly dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on wide integers.
  function automatic exp_t model(input logic sel, input longint a, input longint b, input longint w);
    exp_t   e;
    longint q;
    longint t;
    q    = sel ? 64'd8380417 : 64'd3329;
    t    = (b * w) % q;
    e.sel = sel;
    e.hi  = (a + t) % q;
    e.lo  = (a - t + q) % q;
    return e;
  endfunction

  task automatic drive(input logic vld, input logic sel, input longint a, input longint b, input longint w);
    bus.in_valid_i = vld;
    bus.sel_i      = sel;
    bus.a_i        = a[22:0];
    bus.b_i        = b[22:0];
    bus.w_i        = w[22:0];
  endtask

  // Call on a falling edge with an empty pipeline; checks exact 3-cycle latency.
  task automatic run_op(input string tag, input logic sel, input longint a, input longint b,
                        input longint w, input longint ehi, input longint elo);
    drive(1'b1, sel, a, b, w);
    bus.out_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      chk($sformatf("%s_vld%0d", tag, i), bus.out_valid_o, (i == 3) ? 1 : 0);
    end
    chk({tag, "_hi"}, bus.hi_o, ehi);
    chk({tag, "_lo"}, bus.lo_o, elo);
    chk({tag, "_sel"}, bus.sel_o, sel);
    @(negedge clk);
  endtask

  initial begin
    exp_t   ops[4];
    exp_t   expq[$];
    exp_t   e;
    logic   sel_r;
    longint q, ra, rb, rw;
    int     sent, rcvd, cyc;
    logic   pending;
    longint hold_hi, hold_lo;

    passed = 0;
    failed = 0;
    total  = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    bus.out_ready_i = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    chk("rst_sel", bus.sel_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    run_op("k_1_1_1", 1'b0, 1, 1, 1, 2, 0);
    run_op("k_0_1_1", 1'b0, 0, 1, 1, 1, 3328);
    run_op("k_max", 1'b0, 3328, 3328, 1, 3327, 0);
    run_op("d_hi_wrap", 1'b1, 8380416, 1, 1, 0, 8380415);
    run_op("d_t_one", 1'b1, 0, 2, 4190209, 1, 8380416);

    // Back-pressure: fill all three stages, stall 5 cycles, then drain while
    // a fourth op enters on the same edge the first one leaves.
    ops[0] = model(1'b0, 5, 7, 11);
    ops[1] = model(1'b1, 100, 3, 1000);
    ops[2] = model(1'b0, 3000, 100, 100);
    ops[3] = model(1'b1, 8000000, 12345, 678);
    bus.out_ready_i = 1'b0;
    drive(1'b1, 1'b0, 5, 7, 11);
    @(negedge clk);
    drive(1'b1, 1'b1, 100, 3, 1000);
    @(negedge clk);
    drive(1'b1, 1'b0, 3000, 100, 100);
    @(negedge clk);
    drive(1'b1, 1'b1, 8000000, 12345, 678);
    hold_hi = bus.hi_o;
    hold_lo = bus.lo_o;
    chk("bp_hold_hi_first", hold_hi, ops[0].hi);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_in_ready_%0d", i), bus.in_ready_o, 0);
      chk($sformatf("bp_out_valid_%0d", i), bus.out_valid_o, 1);
      chk($sformatf("bp_busy_%0d", i), bus.busy_o, 1);
      chk($sformatf("bp_stable_hi_%0d", i), bus.hi_o, hold_hi);
      chk($sformatf("bp_stable_lo_%0d", i), bus.lo_o, hold_lo);
      @(negedge clk);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_sim_accept_in_ready", bus.in_ready_o, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain_vld_%0d", k), bus.out_valid_o, 1);
      chk($sformatf("bp_drain_hi_%0d", k), bus.hi_o, ops[k].hi);
      chk($sformatf("bp_drain_lo_%0d", k), bus.lo_o, ops[k].lo);
      chk($sformatf("bp_drain_sel_%0d", k), bus.sel_o, ops[k].sel);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
    end
    chk("bp_drain_empty", bus.out_valid_o, 0);

    // Reset with two ops in flight
    drive(1'b1, 1'b0, 10, 20, 30);
    @(negedge clk);
    drive(1'b1, 1'b1, 40, 50, 60);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    chk("rstmid_busy_before", bus.busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", bus.out_valid_o, 0);
    chk("rstmid_busy", bus.busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 1'b0, 2, 3, 4, 14, 3319);

    // Randomized traffic with random valid/ready gaps
    sent    = 0;
    rcvd    = 0;
    cyc     = 0;
    pending = 1'b0;
    while ((sent < 1000 || rcvd < sent) && cyc < 20000) begin
      if (!pending) begin
        if (sent < 1000 && $urandom_range(3) != 0) begin
          sel_r = 1'($urandom_range(1));
          q     = sel_r ? 64'd8380417 : 64'd3329;
          ra    = longint'($urandom_range(32'(q - 1)));
          rb    = longint'($urandom_range(32'(q - 1)));
          rw    = longint'($urandom_range(32'(q - 1)));
          drive(1'b1, sel_r, ra, rb, rw);
        end else begin
          bus.in_valid_i = 1'b0;
        end
      end
      bus.out_ready_i = ($urandom_range(3) != 0);
      #1;
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (expq.size() == 0) begin
          chk("rnd_unexpected_output", 1, 0);
        end else begin
          e = expq.pop_front();
          chk($sformatf("rnd_hi_%0d", rcvd), bus.hi_o, e.hi);
          chk($sformatf("rnd_lo_%0d", rcvd), bus.lo_o, e.lo);
          chk($sformatf("rnd_sel_%0d", rcvd), bus.sel_o, e.sel);
        end
        rcvd++;
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        expq.push_back(model(bus.sel_i, bus.a_i, bus.b_i, bus.w_i));
        sent++;
        pending = 1'b0;
      end else begin
        pending = bus.in_valid_i;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    chk("rnd_sent", sent, 1000);
    chk("rnd_rcvd", rcvd, 1000);
    chk("rnd_queue_empty", expq.size(), 0);
    chk("rnd_idle_busy", bus.busy_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
